// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command port: FSM states, command word fields, queue entry type.
// No logic of its own; latency n/a.
// Backpressure n/a; consumers decide overflow handling.
package lcd_pkg;

  // Transfer sequencer states, in the order a command walks through them
  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    IDLE  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4,
    EXEC  = 3'd5
  } lcd_state_e;

  // Bit positions inside the 32-bit store word
  localparam int LCD_ON_BIT      = 31;
  localparam int LCD_CLR_OVF_BIT = 30;
  localparam int LCD_RS_BIT      = 9;

  // Panel instructions that need the long execution wait
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // One queued bus transfer: register select plus data byte
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  // Clear and home are instructions (rs=0) that take far longer to execute
  function automatic logic is_long_cmd(input lcd_cmd_t cmd);
    return (!cmd.rs) && ((cmd.data == CMD_CLEAR) || (cmd.data == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command queue holding {rs,data} entries between the store port and the bus sequencer.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens on the same edge; pop ignored when empty.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  lcd_cmd_t                  push_dat,
  input  logic                      pop,
  output lcd_cmd_t                  pop_dat,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);

  lcd_cmd_t        mem [DEPTH];
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic            do_push;
  logic            do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign level   = wptr - rptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wptr == rptr);
  assign pop_dat = mem[rptr[AW-1:0]];

  // A pop on the same edge frees the slot, so a push into a full queue is still taken
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array: written only on accepted pushes, never reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= push_dat;
    end
  end

  // Read/write pointers, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// Replays queued LCD store words onto an HD44780-style 8-bit bus with setup/enable/hold/exec timing.
// Latency: push at edge N raises E at edge N+1+T_SETUP when the sequencer is idle.
// Backpressure: none toward the CPU; a store into a full queue is dropped and flagged in status (ovf).
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int T_PWRUP     = 750000,
  parameter int T_SETUP     = 2,
  parameter int T_PULSE     = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] status_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Counter reload values. Power-up loads one less because the first
  // PWRUP cycle after reset is spent loading a cleared counter.
  localparam logic [31:0] L_PWRUP = (T_PWRUP > 1) ? 32'(T_PWRUP - 1) : 32'd1;
  localparam logic [31:0] L_SETUP = 32'(T_SETUP);
  localparam logic [31:0] L_PULSE = 32'(T_PULSE);
  localparam logic [31:0] L_HOLD  = 32'(T_HOLD);
  localparam logic [31:0] L_EXEC  = 32'(T_EXEC);
  localparam logic [31:0] L_LONG  = 32'(T_EXEC_LONG);

  lcd_state_e     state;
  logic [31:0]    cnt;
  logic           ovf;

  lcd_cmd_t       wr_cmd;
  lcd_cmd_t       head;
  lcd_cmd_t       cur_cmd;
  logic           clr_req;
  logic           push_req;
  logic           pop;
  logic           full;
  logic           empty;
  logic [LW-1:0]  level;
  logic           busy;
  logic           unused_bits;

  // Decode the store word: a clr_ovf store is a control write and never enters the queue
  assign wr_cmd   = '{rs: wr_data_i[LCD_RS_BIT], data: wr_data_i[7:0]};
  assign clr_req  = wr_en_i &&  wr_data_i[LCD_CLR_OVF_BIT];
  assign push_req = wr_en_i && !wr_data_i[LCD_CLR_OVF_BIT];
  assign unused_bits = ^{wr_data_i[29:10], wr_data_i[8]};

  // The sequencer takes the head only while idle
  assign pop = (state == IDLE) && !empty;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (push_req),
    .push_dat (wr_cmd),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // Busy covers power-up, any transfer in flight and anything still queued
  assign busy     = (state != IDLE) || !empty;
  assign status_o = {lcd_on_o, ovf, 20'b0, 8'(level), full, busy};

  // The panel is write-only; no busy-flag readback
  assign lcd_rw_o = 1'b0;

  // The bus outputs double as the latch for the command being replayed
  assign cur_cmd = '{rs: lcd_rs_o, data: lcd_data_o};

  // Power/backlight follows every store, whether or not the word is queued
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lcd_on_o <= 1'b0;
    end else if (wr_en_i) begin
      lcd_on_o <= wr_data_i[LCD_ON_BIT];
    end
  end

  // Sticky overflow: set when a store is lost to a full queue, cleared only by software
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf <= 1'b0;
    end else if (clr_req) begin
      ovf <= 1'b0;
    end else if (push_req && full && !pop) begin
      ovf <= 1'b1;
    end
  end

  // Transfer sequencer: one down-counter loaded on state entry, leave the state when it reads 1
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= PWRUP;
      cnt        <= '0;
      lcd_en_o   <= 1'b0;
      lcd_rs_o   <= 1'b0;
      lcd_data_o <= 8'h00;
    end else begin
      case (state)
        PWRUP: begin
          if (cnt == 32'd1) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 32'd0) begin
            cnt <= L_PWRUP;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        IDLE: begin
          // Bus lines move only here; they keep the last value while idle
          if (!empty) begin
            state      <= SETUP;
            cnt        <= L_SETUP;
            lcd_rs_o   <= head.rs;
            lcd_data_o <= head.data;
          end
        end
        SETUP: begin
          if (cnt == 32'd1) begin
            state    <= PULSE;
            cnt      <= L_PULSE;
            lcd_en_o <= 1'b1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        PULSE: begin
          if (cnt == 32'd1) begin
            state    <= HOLD;
            cnt      <= L_HOLD;
            lcd_en_o <= 1'b0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        HOLD: begin
          if (cnt == 32'd1) begin
            state <= EXEC;
            cnt   <= is_long_cmd(cur_cmd) ? L_LONG : L_EXEC;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        EXEC: begin
          if (cnt == 32'd1) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: begin
          state    <= PWRUP;
          cnt      <= '0;
          lcd_en_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
